branch_sequencer: RTL and testbench

- Consumes branch requests (operand pair, 2-bit compare op, target) and resolves them internally with the team's comparator encoding.
- Drives the program counter: sequential increment, stall hold, or redirect to target on a taken branch.
- On a taken branch, asserts a one-cycle flush toward fetch/decode. Also keeps a saturating count of taken branches for debug.
- Sits between decode (branch issue) and instruction fetch (PC consumer).

---
 rtl/branch_sequencer_if.sv | 22 ++
 rtl/branch_sequencer.sv | 119 +++++++++++
 tb/tb_branch_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Branch issue channel between decode and the branch sequencer.
// Decode drives the request; the sequencer answers with branch_ready.
interface branch_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             branch_valid;
  logic [1:0]       operation;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] target;
  logic             branch_ready;

  modport master (
    output branch_valid, operation, r0, r1, target,
    input  branch_ready
  );

  modport slave (
    input  branch_valid, operation, r0, r1, target,
    output branch_ready
  );
endinterface

// File: rtl/branch_sequencer.sv
// Program counter sequencer: increments, holds on stall, or redirects on a taken branch.
// A taken branch is followed by a single flush cycle and bumps a saturating debug counter.
module branch_sequencer #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  branch_sequencer_if.slave      br,
  output logic [WIDTH-1:0]       pc,
  output logic                   pc_valid,
  output logic                   flush,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]       PC_ONE    = 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       pc_reg, pc_next;
  logic [1:0]             op_reg, op_next;
  logic [WIDTH-1:0]       r0_reg, r0_next;
  logic [WIDTH-1:0]       r1_reg, r1_next;
  logic [WIDTH-1:0]       target_reg, target_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic                   taken;

  // Decision is made only from the operands captured at acceptance.
  always_comb begin
    taken = 1'b0;
    case (op_reg)
      2'b00:   taken = (r0_reg < r1_reg);
      2'b01:   taken = (r0_reg > r1_reg);
      2'b10:   taken = (r0_reg == r1_reg);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      op_reg     <= '0;
      r0_reg     <= '0;
      r1_reg     <= '0;
      target_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      op_reg     <= op_next;
      r0_reg     <= r0_next;
      r1_reg     <= r1_next;
      target_reg <= target_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    op_next     = op_reg;
    r0_next     = r0_reg;
    r1_next     = r1_reg;
    target_next = target_reg;
    count_next  = count_reg;
    case (state_reg)
      RUN: begin
        if (!stall) begin
          if (br.branch_valid) begin
            op_next     = br.operation;
            r0_next     = br.r0;
            r1_next     = br.r1;
            target_next = br.target;
            state_next  = RESOLVE;
          end else begin
            pc_next = pc_reg + PC_ONE;
          end
        end
      end
      RESOLVE: begin
        if (!stall) begin
          if (taken) begin
            pc_next    = target_reg;
            state_next = FLUSH;
            if (count_reg != '1) begin
              count_next = count_reg + COUNT_ONE;
            end
          end else begin
            pc_next    = pc_reg + PC_ONE;
            state_next = RUN;
          end
        end
      end
      FLUSH: begin
        // Flush is a fixed one-cycle bubble; stall does not extend it.
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign pc              = pc_reg;
  assign pc_valid        = (state_reg == RUN);
  assign br.branch_ready = (state_reg == RUN) && !stall;
  assign flush           = (state_reg == FLUSH);
  assign taken_count     = count_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios then random traffic, with a
// transaction-level reference model feeding a per-cycle scoreboard.
module tb_branch_sequencer;

  localparam int         WIDTH  = 16;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int         CW     = 2;
  localparam int         CMAX   = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            stall = 1'b0;
  logic [15:0]     pc;
  logic            pc_valid;
  logic            flush;
  logic [CW-1:0]   taken_count;

  branch_sequencer_if #(.WIDTH(WIDTH)) bif ();

  branch_sequencer #(
    .WIDTH(WIDTH),
    .RESET_PC(RST_PC),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .br(bif),
    .pc(pc),
    .pc_valid(pc_valid),
    .flush(flush),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic        valid;
    logic        ready;
    logic        flush;
    int          count;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: a branch's outcome is decided at the moment it is accepted.
  logic [15:0] m_pc = RST_PC;
  int          m_count = 0;
  bit          have_pending = 0;
  bit          pend_taken = 0;
  logic [15:0] pend_target = '0;
  bit          flush_now = 0;

  function automatic bit ref_taken(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    case (op)
      2'd0:    return ua < ub;
      2'd1:    return ua > ub;
      2'd2:    return ua == ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit rst, input bit bv, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] t, input bit st);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    reset_n          = !rst;
    stall            = st;
    bif.branch_valid = bv;
    bif.operation    = op;
    bif.r0           = a;
    bif.r1           = b;
    bif.target       = t;
    if (rst) begin
      m_pc = RST_PC; m_count = 0; have_pending = 0; flush_now = 0;
    end
    e.cyc   = cyc;
    e.pc    = m_pc;
    e.valid = !have_pending && !flush_now;
    e.ready = e.valid && !st;
    e.flush = flush_now;
    e.count = m_count;
    sb.push_back(e);
    if (!rst) begin
      if (flush_now) begin
        flush_now = 0;
      end else if (have_pending) begin
        if (!st) begin
          have_pending = 0;
          if (pend_taken) begin
            m_pc = pend_target;
            m_count = (m_count >= CMAX) ? CMAX : m_count + 1;
            flush_now = 1;
          end else begin
            m_pc = m_pc + 16'd1;
          end
        end
      end else if (!st) begin
        if (bv) begin
          have_pending = 1;
          pend_taken   = ref_taken(op, a, b);
          pend_target  = t;
          $display("cycle %0d: branch accepted pc=%h op=%0d r0=%h r1=%h target=%h taken=%0d",
                   cyc, m_pc, op, a, b, t, pend_taken);
        end else begin
          m_pc = m_pc + 16'd1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic branch(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] t);
    drive(0, 1, op, a, b, t, 0);
  endtask

  function automatic void check(input string name, input int c, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, expv);
    end
  endfunction

  // Monitor: compares the DUT outputs of each cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", e.cyc, 32'(pc), 32'(e.pc));
        check("pc_valid", e.cyc, 32'(pc_valid), 32'(e.valid));
        check("branch_ready", e.cyc, 32'(bif.branch_ready), 32'(e.ready));
        check("flush", e.cyc, 32'(flush), 32'(e.flush));
        check("taken_count", e.cyc, 32'(taken_count), 32'(e.count));
      end
    end
  end

  initial begin
    bif.branch_valid = 0;
    bif.operation    = 0;
    bif.r0           = 0;
    bif.r1           = 0;
    bif.target       = 0;
    drive(1, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
    drive(1, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
    idle(4);
    branch(2'd0, 16'h0003, 16'h0005, 16'h0100);
    idle(3);
    branch(2'd1, 16'h7FFF, 16'h7FFF, 16'h0055);
    idle(1);
    branch(2'd2, 16'h7FFF, 16'h7FFF, 16'h0020);
    idle(2);
    branch(2'd3, 16'h0001, 16'h0002, 16'h0999);
    idle(1);
    branch(2'd0, 16'hFFFF, 16'h0001, 16'h0777);
    idle(1);
    branch(2'd2, 16'h0000, 16'h0000, 16'hFFFE);
    idle(4);
    // Stall in RUN with a pending request, then release.
    for (int i = 0; i < 3; i++) drive(0, 1, 2'd1, 16'h0009, 16'h0002, 16'h0400, 1);
    drive(0, 1, 2'd1, 16'h0009, 16'h0002, 16'h0400, 0);
    // Held RESOLVE while the operand inputs change underneath.
    drive(0, 0, 2'd1, 16'h0000, 16'hFFFF, 16'h0000, 1);
    drive(0, 0, 2'd1, 16'h0000, 16'hFFFF, 16'h0000, 1);
    drive(0, 0, 2'd1, 16'h0000, 16'hFFFF, 16'h0000, 0);
    drive(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1);
    idle(2);
    // Reset in the middle of resolving a taken branch.
    branch(2'd0, 16'h0001, 16'h0002, 16'h0300);
    drive(1, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 0);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      branch(2'd2, 16'h1234, 16'h1234, 16'(16'h0010 * (i + 1)));
      idle(2);
    end
    // Random traffic with operand equality biased in and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a, b, t;
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      t = 16'($urandom);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)), a, b, t, ($urandom_range(0, 3) == 0));
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
